// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 32:1 mux feeding a single valid/ready consumer.
// The winner's index drives the mux select. The winner gets a one-hot ack when its
// transfer is accepted.
module mux32_rr_arbiter #(
  parameter int unsigned N_REQ = 32,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] ack,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] masked;
  logic             handshake;

  // First set bit of m, searching base+1, base+2, ... with wrap-around.
  function automatic logic [SEL_W-1:0] pick(input logic [N_REQ-1:0] m,
                                            input logic [SEL_W-1:0] base);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = SEL_W'((32'(base) + i) % N_REQ);
      if (!found && m[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Current winner removed, so it cannot win twice in a row while others wait.
  assign masked    = req & ~(N_REQ'(1) << sel_q);
  assign handshake = valid_q & out_ready & req[sel_q];

  // Arbitration FSM: grant, hold until handshake or withdrawal, chain back-to-back grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            sel_q   <= pick(req, last_q);
            valid_q <= 1'b1;
            state_q <= StBusy;
          end else begin
            valid_q <= 1'b0;
          end
        end
        StBusy: begin
          if (!req[sel_q]) begin
            // Withdrawal: drop the offer without touching last or the count.
            valid_q <= 1'b0;
            state_q <= StIdle;
          end else if (handshake) begin
            last_q <= sel_q;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (|masked) begin
              sel_q <= pick(masked, sel_q);
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // One-hot ack to the winner in the cycle its transfer is accepted.
  always_comb begin
    ack = '0;
    if (handshake) begin
      ack[sel_q] = 1'b1;
    end
  end

  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;

endmodule
